// File: rtl/ahb_burst_tracker.sv
// AHB-Lite slave-side burst tracker: predicts each data-phase beat address,
// counts beats, flags the last beat and pulses protocol-violation flags.
module ahb_burst_tracker #(
  parameter int ADDR_W   = 10,
  parameter int MAX_SIZE = 3,
  parameter int BOUND_W  = 10,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic              hready,
  output logic              burst_active,
  output logic              beat_valid,
  output logic [ADDR_W-1:0] beat_addr,
  output logic [CNT_W-1:0]  beat_idx,
  output logic              last_beat,
  output logic              addr_err,
  output logic              seq_err,
  output logic              size_err,
  output logic              bound_err
);

  typedef enum logic [1:0] {
    TR_IDLE   = 2'd0,
    TR_BUSY   = 2'd1,
    TR_NONSEQ = 2'd2,
    TR_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic { ST_IDLE, ST_ACTIVE } state_t;

  localparam logic [2:0]        MAX_SZ  = 3'(MAX_SIZE);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  ONE_C   = CNT_W'(1);

  state_t            state;
  logic [2:0]        burst_q;
  logic [2:0]        size_q;
  logic [4:0]        len_q;     // 0 encodes undefined-length INCR
  logic [ADDR_W-1:0] inc_q;
  logic [ADDR_W-1:0] wmask_q;

  function automatic logic [4:0] burst_len(input logic [2:0] b);
    case (b)
      3'd0:       return 5'd1;
      3'd1:       return 5'd0;
      3'd2, 3'd3: return 5'd4;
      3'd4, 3'd5: return 5'd8;
      default:    return 5'd16;
    endcase
  endfunction

  function automatic logic crosses(input logic [ADDR_W-1:0] a,
                                   input logic [ADDR_W-1:0] b);
    return (a >> BOUND_W) != (b >> BOUND_W);
  endfunction

  logic              is_nonseq, is_seq, is_busy;
  logic [4:0]        len_in;
  logic [ADDR_W-1:0] inc_in, wmask_in, pred_addr;
  logic [CNT_W-1:0]  idx_inc;
  logic              size_bad, at_end, last_seq, seq_mismatch;

  assign is_nonseq = hsel && (htrans == TR_NONSEQ);
  assign is_seq    = hsel && (htrans == TR_SEQ);
  assign is_busy   = hsel && (htrans == TR_BUSY);

  assign len_in   = burst_len(hburst);
  assign inc_in   = ONE_A << hsize;
  assign wmask_in = ADDR_W'((32'(len_in) << hsize) - 32'd1);

  // Odd HBURST codes are the incrementing types; even non-zero codes wrap.
  assign pred_addr = burst_q[0] ? beat_addr + inc_q
                                : (beat_addr & ~wmask_q) | ((beat_addr + inc_q) & wmask_q);

  assign size_bad     = (hsize > MAX_SZ) || ((haddr & (inc_in - ONE_A)) != '0);
  assign at_end       = (len_q != 5'd0) && (32'(beat_idx) + 32'd1 == 32'(len_q));
  assign last_seq     = (len_q != 5'd0) && (32'(beat_idx) + 32'd2 == 32'(len_q));
  assign idx_inc      = (&beat_idx) ? beat_idx : beat_idx + ONE_C;
  assign seq_mismatch = (haddr != pred_addr) || (hsize != size_q) || (hburst != burst_q);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= ST_IDLE;
      burst_q      <= '0;
      size_q       <= '0;
      len_q        <= '0;
      inc_q        <= '0;
      wmask_q      <= '0;
      burst_active <= 1'b0;
      beat_valid   <= 1'b0;
      beat_addr    <= '0;
      beat_idx     <= '0;
      last_beat    <= 1'b0;
      addr_err     <= 1'b0;
      seq_err      <= 1'b0;
      size_err     <= 1'b0;
      bound_err    <= 1'b0;
    end else begin
      addr_err  <= 1'b0;
      seq_err   <= 1'b0;
      size_err  <= 1'b0;
      bound_err <= 1'b0;
      if (hready) begin
        if (is_nonseq) begin
          state        <= (len_in == 5'd1) ? ST_IDLE : ST_ACTIVE;
          burst_active <= (len_in != 5'd1);
          burst_q      <= hburst;
          size_q       <= hsize;
          len_q        <= len_in;
          inc_q        <= inc_in;
          wmask_q      <= wmask_in;
          beat_addr    <= haddr;
          beat_idx     <= '0;
          beat_valid   <= 1'b1;
          last_beat    <= (len_in == 5'd1);
          size_err     <= size_bad;
          bound_err    <= hburst[0] && crosses(haddr, haddr + inc_in);
        end else if (is_seq) begin
          size_err <= size_bad;
          if (state == ST_IDLE || at_end) begin
            seq_err      <= 1'b1;
            beat_valid   <= 1'b0;
            last_beat    <= 1'b0;
            state        <= ST_IDLE;
            burst_active <= 1'b0;
          end else begin
            // A wrong haddr is flagged but the prediction stays authoritative.
            beat_addr  <= pred_addr;
            beat_idx   <= idx_inc;
            beat_valid <= 1'b1;
            last_beat  <= last_seq;
            addr_err   <= seq_mismatch;
            bound_err  <= burst_q[0] && !last_seq && crosses(pred_addr, pred_addr + inc_q);
          end
        end else begin
          beat_valid <= 1'b0;
          last_beat  <= 1'b0;
          if (!is_busy) begin
            state        <= ST_IDLE;
            burst_active <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_burst_tracker.sv
// Bench for ahb_burst_tracker: directed vector table, hand-written reset and
// saturation sequences, then constrained-random traffic against a burst model.
module tb_ahb_burst_tracker;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_BUSY   = 2'd1;
  localparam logic [1:0] T_NONSEQ = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;

  typedef struct packed {
    logic        hsel;
    logic [1:0]  htrans;
    logic [11:0] haddr;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hready;
  } in_t;

  typedef struct packed {
    logic        act;
    logic        bv;
    logic [11:0] ba;
    logic [7:0]  bi;
    logic        lb;
    logic        ae;
    logic        se;
    logic        ze;
    logic        be;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        hsel, hready;
  logic [11:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic        burst_active, beat_valid, last_beat;
  logic        addr_err, seq_err, size_err, bound_err;
  logic [11:0] beat_addr;
  logic [7:0]  beat_idx;
  out_t        dut_out;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[$];

  ahb_burst_tracker #(.ADDR_W(12), .MAX_SIZE(3), .BOUND_W(10), .CNT_W(8)) dut (
    .clk(clk), .n_rst(n_rst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hsize(hsize), .hburst(hburst), .hready(hready),
    .burst_active(burst_active), .beat_valid(beat_valid), .beat_addr(beat_addr),
    .beat_idx(beat_idx), .last_beat(last_beat), .addr_err(addr_err),
    .seq_err(seq_err), .size_err(size_err), .bound_err(bound_err)
  );

  assign dut_out = {burst_active, beat_valid, beat_addr, beat_idx, last_beat,
                    addr_err, seq_err, size_err, bound_err};

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  function automatic string fmt(input out_t o);
    return $sformatf("act=%0b bv=%0b addr=%03h idx=%0d last=%0b ae=%0b se=%0b ze=%0b be=%0b",
                     o.act, o.bv, o.ba, o.bi, o.lb, o.ae, o.se, o.ze, o.be);
  endfunction

  task automatic check(input string name, input out_t got, input out_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got {%s} want {%s}", name, fmt(got), fmt(exp));
    end
  endtask

  function automatic in_t mk_in(input logic hs, input logic [1:0] ht, input logic [11:0] a,
                                input logic [2:0] sz, input logic [2:0] bu, input logic rdy);
    in_t v;
    v.hsel = hs; v.htrans = ht; v.haddr = a; v.hsize = sz; v.hburst = bu; v.hready = rdy;
    return v;
  endfunction

  // ab = {burst_active, beat_valid}; fl = {last, addr_err, seq_err, size_err, bound_err}
  function automatic out_t mk_out(input logic [1:0] ab, input logic [11:0] ba,
                                  input logic [7:0] bi, input logic [4:0] fl);
    out_t o;
    {o.act, o.bv} = ab;
    o.ba = ba;
    o.bi = bi;
    {o.lb, o.ae, o.se, o.ze, o.be} = fl;
    return o;
  endfunction

  function automatic void add_vec(input string nm, input in_t i, input out_t o);
    vec_t v;
    v.name = nm; v.i = i; v.o = o;
    vecs.push_back(v);
  endfunction

  task automatic apply(input in_t v);
    hsel = v.hsel; htrans = v.htrans; haddr = v.haddr;
    hsize = v.hsize; hburst = v.hburst; hready = v.hready;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a burst is its start address, size, type and beat count;
  // every beat address is derived directly from those with plain arithmetic.
  bit   m_active;
  int   m_start, m_size, m_burst, m_len, m_k;
  out_t m_out;

  function automatic int len_of(input int b);
    case (b)
      0: return 1;
      1: return 0;
      2, 3: return 4;
      4, 5: return 8;
      default: return 16;
    endcase
  endfunction

  function automatic int addr_at(input int k);
    int inc  = 1 << m_size;
    int span = m_len * inc;
    if (m_burst != 0 && m_burst % 2 == 0)
      return ((m_start / span) * span + (m_start % span + k * inc) % span) % 4096;
    return (m_start + k * inc) % 4096;
  endfunction

  function automatic bit bound_hit(input int k);
    bit last = (m_len != 0) && (k == m_len - 1);
    return (m_burst % 2 == 1) && !last && ((addr_at(k) / 1024) != (addr_at(k + 1) / 1024));
  endfunction

  function automatic bit size_bad(input in_t v);
    return (v.hsize > 3'd3) || ((int'(v.haddr) % (1 << v.hsize)) != 0);
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_start = 0; m_size = 0; m_burst = 0; m_len = 0; m_k = 0;
    m_out = '0;
  endtask

  task automatic model_step(input in_t v);
    int a;
    m_out.ae = 1'b0; m_out.se = 1'b0; m_out.ze = 1'b0; m_out.be = 1'b0;
    if (!v.hready) return;
    if (v.hsel && v.htrans == T_NONSEQ) begin
      m_start = int'(v.haddr); m_size = int'(v.hsize); m_burst = int'(v.hburst);
      m_len = len_of(m_burst); m_k = 0;
      m_active = (m_len != 1);
      m_out.bv = 1'b1; m_out.ba = v.haddr; m_out.bi = 8'd0;
      m_out.lb = (m_len == 1);
      m_out.ze = size_bad(v);
      m_out.be = bound_hit(0);
    end else if (v.hsel && v.htrans == T_SEQ) begin
      m_out.ze = size_bad(v);
      if (!m_active || (m_len != 0 && m_k == m_len - 1)) begin
        m_out.se = 1'b1; m_out.bv = 1'b0; m_out.lb = 1'b0;
        m_active = 1'b0;
      end else begin
        m_k++;
        a = addr_at(m_k);
        m_out.bv = 1'b1;
        m_out.ba = 12'(a);
        m_out.bi = (m_k > 255) ? 8'd255 : 8'(m_k);
        m_out.lb = (m_len != 0) && (m_k == m_len - 1);
        m_out.ae = (int'(v.haddr) != a) || (int'(v.hsize) != m_size) || (int'(v.hburst) != m_burst);
        m_out.be = bound_hit(m_k);
      end
    end else begin
      m_out.bv = 1'b0; m_out.lb = 1'b0;
      if (!(v.hsel && v.htrans == T_BUSY)) m_active = 1'b0;
    end
    m_out.act = m_active;
  endtask

  function automatic in_t gen_rand();
    in_t r;
    int p = m_active ? $urandom_range(0, 99) : $urandom_range(70, 99);
    r.hready = ($urandom_range(0, 5) != 0);
    r.hsel   = ($urandom_range(0, 15) != 0);
    r.hsize  = 3'(m_size);
    r.hburst = 3'(m_burst);
    r.haddr  = 12'($urandom);
    if (p < 70) begin
      r.htrans = T_SEQ;
      if (p < 64) r.haddr = 12'(addr_at(m_k + 1));
      if (p == 68) r.hsize = 3'($urandom);
      if (p == 69) r.hburst = 3'($urandom);
    end else if (p < 78) r.htrans = T_BUSY;
    else if (p < 85) r.htrans = T_IDLE;
    else if (p < 88) r.htrans = T_SEQ;
    else begin
      r.htrans = T_NONSEQ;
      r.hsize  = 3'($urandom_range(0, ($urandom_range(0, 9) == 0) ? 7 : 3));
      r.hburst = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) != 0) r.haddr = r.haddr & ~12'((1 << r.hsize) - 1);
    end
    return r;
  endfunction

  task automatic build_table();
    // WRAP4, word beats, wrapping inside a 16-byte window
    add_vec("wrap4_b0", mk_in(1'b1, T_NONSEQ, 12'h038, 3'd2, 3'd2, 1'b1), mk_out(2'b11, 12'h038, 8'd0, 5'b00000));
    add_vec("wrap4_b1", mk_in(1'b1, T_SEQ,    12'h03C, 3'd2, 3'd2, 1'b1), mk_out(2'b11, 12'h03C, 8'd1, 5'b00000));
    add_vec("wrap4_b2", mk_in(1'b1, T_SEQ,    12'h030, 3'd2, 3'd2, 1'b1), mk_out(2'b11, 12'h030, 8'd2, 5'b00000));
    add_vec("wrap4_b3", mk_in(1'b1, T_SEQ,    12'h034, 3'd2, 3'd2, 1'b1), mk_out(2'b11, 12'h034, 8'd3, 5'b10000));
    add_vec("wrap4_end", mk_in(1'b1, T_IDLE,  12'h000, 3'd0, 3'd0, 1'b1), mk_out(2'b00, 12'h034, 8'd3, 5'b00000));
    // INCR8, doubleword beats, with BUSY and a two-cycle stall
    add_vec("incr8_b0", mk_in(1'b1, T_NONSEQ, 12'h100, 3'd3, 3'd5, 1'b1), mk_out(2'b11, 12'h100, 8'd0, 5'b00000));
    add_vec("incr8_b1", mk_in(1'b1, T_SEQ,    12'h108, 3'd3, 3'd5, 1'b1), mk_out(2'b11, 12'h108, 8'd1, 5'b00000));
    add_vec("incr8_b2", mk_in(1'b1, T_SEQ,    12'h110, 3'd3, 3'd5, 1'b1), mk_out(2'b11, 12'h110, 8'd2, 5'b00000));
    add_vec("incr8_busy", mk_in(1'b1, T_BUSY, 12'h118, 3'd3, 3'd5, 1'b1), mk_out(2'b10, 12'h110, 8'd2, 5'b00000));
    add_vec("incr8_b3", mk_in(1'b1, T_SEQ,    12'h118, 3'd3, 3'd5, 1'b1), mk_out(2'b11, 12'h118, 8'd3, 5'b00000));
    add_vec("incr8_b4", mk_in(1'b1, T_SEQ,    12'h120, 3'd3, 3'd5, 1'b1), mk_out(2'b11, 12'h120, 8'd4, 5'b00000));
    add_vec("incr8_stall0", mk_in(1'b1, T_SEQ, 12'h128, 3'd3, 3'd5, 1'b0), mk_out(2'b11, 12'h120, 8'd4, 5'b00000));
    add_vec("incr8_stall1", mk_in(1'b1, T_SEQ, 12'h128, 3'd3, 3'd5, 1'b0), mk_out(2'b11, 12'h120, 8'd4, 5'b00000));
    add_vec("incr8_b5", mk_in(1'b1, T_SEQ,    12'h128, 3'd3, 3'd5, 1'b1), mk_out(2'b11, 12'h128, 8'd5, 5'b00000));
    add_vec("incr8_b6", mk_in(1'b1, T_SEQ,    12'h130, 3'd3, 3'd5, 1'b1), mk_out(2'b11, 12'h130, 8'd6, 5'b00000));
    add_vec("incr8_b7", mk_in(1'b1, T_SEQ,    12'h138, 3'd3, 3'd5, 1'b1), mk_out(2'b11, 12'h138, 8'd7, 5'b10000));
    add_vec("incr8_desel", mk_in(1'b0, T_IDLE, 12'h000, 3'd0, 3'd0, 1'b1), mk_out(2'b00, 12'h138, 8'd7, 5'b00000));
    // Undefined INCR across the 1KB boundary
    add_vec("bound_b0", mk_in(1'b1, T_NONSEQ, 12'h3F8, 3'd2, 3'd1, 1'b1), mk_out(2'b11, 12'h3F8, 8'd0, 5'b00000));
    add_vec("bound_b1", mk_in(1'b1, T_SEQ,    12'h3FC, 3'd2, 3'd1, 1'b1), mk_out(2'b11, 12'h3FC, 8'd1, 5'b00001));
    add_vec("bound_b2", mk_in(1'b1, T_SEQ,    12'h400, 3'd2, 3'd1, 1'b1), mk_out(2'b11, 12'h400, 8'd2, 5'b00000));
    add_vec("bound_b3", mk_in(1'b1, T_SEQ,    12'h404, 3'd2, 3'd1, 1'b1), mk_out(2'b11, 12'h404, 8'd3, 5'b00000));
    add_vec("bound_end", mk_in(1'b1, T_IDLE,  12'h000, 3'd0, 3'd0, 1'b1), mk_out(2'b00, 12'h404, 8'd3, 5'b00000));
    // Orphan SEQ, wrong address, stall clearing a pulse, over-length SEQ
    add_vec("orphan_seq", mk_in(1'b1, T_SEQ,  12'h200, 3'd2, 3'd3, 1'b1), mk_out(2'b00, 12'h404, 8'd3, 5'b00100));
    add_vec("incr4_b0", mk_in(1'b1, T_NONSEQ, 12'h010, 3'd2, 3'd3, 1'b1), mk_out(2'b11, 12'h010, 8'd0, 5'b00000));
    add_vec("incr4_b1", mk_in(1'b1, T_SEQ,    12'h014, 3'd2, 3'd3, 1'b1), mk_out(2'b11, 12'h014, 8'd1, 5'b00000));
    add_vec("incr4_badaddr", mk_in(1'b1, T_SEQ, 12'h020, 3'd2, 3'd3, 1'b1), mk_out(2'b11, 12'h018, 8'd2, 5'b01000));
    add_vec("incr4_stall", mk_in(1'b1, T_SEQ, 12'h01C, 3'd2, 3'd3, 1'b0), mk_out(2'b11, 12'h018, 8'd2, 5'b00000));
    add_vec("incr4_b3", mk_in(1'b1, T_SEQ,    12'h01C, 3'd2, 3'd3, 1'b1), mk_out(2'b11, 12'h01C, 8'd3, 5'b10000));
    add_vec("incr4_fifth", mk_in(1'b1, T_SEQ, 12'h020, 3'd2, 3'd3, 1'b1), mk_out(2'b00, 12'h01C, 8'd3, 5'b00100));
    // Size violations on SINGLE transfers
    add_vec("misaligned", mk_in(1'b1, T_NONSEQ, 12'h002, 3'd2, 3'd0, 1'b1), mk_out(2'b01, 12'h002, 8'd0, 5'b10010));
    add_vec("oversize", mk_in(1'b1, T_NONSEQ, 12'h010, 3'd4, 3'd0, 1'b1), mk_out(2'b01, 12'h010, 8'd0, 5'b10010));
    add_vec("single_end", mk_in(1'b1, T_IDLE, 12'h000, 3'd0, 3'd0, 1'b1), mk_out(2'b00, 12'h010, 8'd0, 5'b00000));
    // hsize change inside a burst
    add_vec("hsz_b0", mk_in(1'b1, T_NONSEQ, 12'h040, 3'd2, 3'd3, 1'b1), mk_out(2'b11, 12'h040, 8'd0, 5'b00000));
    add_vec("hsz_change", mk_in(1'b1, T_SEQ, 12'h044, 3'd1, 3'd3, 1'b1), mk_out(2'b11, 12'h044, 8'd1, 5'b01000));
    add_vec("hsz_desel", mk_in(1'b0, T_IDLE, 12'h000, 3'd0, 3'd0, 1'b1), mk_out(2'b00, 12'h044, 8'd1, 5'b00000));
  endtask

  initial begin
    in_t r;
    n_rst = 1'b0; hsel = 1'b0; htrans = T_IDLE; haddr = '0;
    hsize = '0; hburst = '0; hready = 1'b1;
    build_table();
    #12;
    check("reset_state", dut_out, '0);
    #1 n_rst = 1'b1;

    foreach (vecs[k]) begin
      apply(vecs[k].i);
      check(vecs[k].name, dut_out, vecs[k].o);
    end

    // Asynchronous reset in the middle of a WRAP8 burst
    apply(mk_in(1'b1, T_NONSEQ, 12'h0C8, 3'd2, 3'd4, 1'b1));
    check("wrap8_b0", dut_out, mk_out(2'b11, 12'h0C8, 8'd0, 5'b00000));
    apply(mk_in(1'b1, T_SEQ, 12'h0CC, 3'd2, 3'd4, 1'b1));
    check("wrap8_b1", dut_out, mk_out(2'b11, 12'h0CC, 8'd1, 5'b00000));
    apply(mk_in(1'b1, T_SEQ, 12'h0D0, 3'd2, 3'd4, 1'b1));
    check("wrap8_b2", dut_out, mk_out(2'b11, 12'h0D0, 8'd2, 5'b00000));
    #3 n_rst = 1'b0;
    #1 check("async_reset", dut_out, '0);
    #1;
    haddr = 12'h0D4;
    n_rst = 1'b1;
    @(posedge clk);
    #1 check("seq_after_reset", dut_out, mk_out(2'b00, 12'h000, 8'd0, 5'b00100));

    // Long undefined INCR: index saturation and a boundary crossing at 0x3FF
    n_rst = 1'b0;
    model_reset();
    #2 n_rst = 1'b1;
    r = mk_in(1'b1, T_NONSEQ, 12'h300, 3'd0, 3'd1, 1'b1);
    apply(r); model_step(r);
    check("long_b0", dut_out, m_out);
    for (int c = 0; c < 300; c++) begin
      r = mk_in(1'b1, T_SEQ, 12'(addr_at(m_k + 1)), 3'd0, 3'd1, 1'b1);
      apply(r); model_step(r);
      check($sformatf("long_b%0d", c + 1), dut_out, m_out);
    end

    // Constrained-random traffic against the model
    n_rst = 1'b0;
    model_reset();
    #2 n_rst = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      r = gen_rand();
      apply(r); model_step(r);
      check($sformatf("rand%0d", c), dut_out, m_out);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
